// File: rtl/seg_scan_if.sv
// Display bus seen by the scan reader: multiplexed segment/strobe lines in,
// debounced digit values and status pulses out.
interface seg_scan_if #(
   parameter int NUM_DIGITS = 4
);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   logic [6:0]              seg_n;
   logic [NUM_DIGITS-1:0]   dig_n;
   logic [4*NUM_DIGITS-1:0] digits_o;
   logic [NUM_DIGITS-1:0]   valid_o;
   logic                    update_o;
   logic [IDX_W-1:0]        update_idx_o;
   logic                    pattern_err_o;
   logic                    scan_err_o;

   // display driver side
   modport master (
      output seg_n, dig_n,
      input  digits_o, valid_o, update_o, update_idx_o, pattern_err_o, scan_err_o
   );

   // reader side
   modport slave (
      input  seg_n, dig_n,
      output digits_o, valid_o, update_o, update_idx_o, pattern_err_o, scan_err_o
   );
endinterface

// File: rtl/seg_scan_reader.sv
// Receive-side reader for a multiplexed 7-segment bus. Waits for a single
// strobe, lets it settle, samples and decodes the segments once, then
// debounces each digit over successive scans before publishing it.
//
// state  | meaning
// IDLE   | waiting for exactly one strobe low
// SETTLE | strobe latched, counting SETTLE_CYC constant cycles
// SAMPLE | decode segments for the latched digit, update debounce
// HOLD   | sample done, wait for the strobe to change
module seg_scan_reader #(
   parameter int NUM_DIGITS   = 4,
   parameter int SETTLE_CYC   = 4,
   parameter int STABLE_SCANS = 3
) (
   input  logic      clk,
   input  logic      rst_n,
   seg_scan_if.slave bus
);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam int CNT_W = $clog2(STABLE_SCANS + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, SAMPLE = 2'd2, HOLD = 2'd3} state_t;

   logic [6:0]              seg_s1, seg_s2;
   logic [NUM_DIGITS-1:0]   dig_s1, dig_s2;
   state_t                  state;
   logic [NUM_DIGITS-1:0]   lat_vec;
   logic [IDX_W-1:0]        lat_idx;
   logic [SET_W-1:0]        scnt;
   logic [3:0]              cand [NUM_DIGITS];
   logic [CNT_W-1:0]        cnt  [NUM_DIGITS];
   logic [4*NUM_DIGITS-1:0] digits;
   logic [NUM_DIGITS-1:0]   valid;
   logic                    update;
   logic [IDX_W-1:0]        update_idx;
   logic                    pattern_err;
   logic                    scan_err;

   logic [NUM_DIGITS-1:0]   dig_low;
   logic                    one_hot, multi_low;
   logic [IDX_W-1:0]        hot_idx;
   logic                    seg_ok;
   logic [3:0]              seg_code;
   logic [3:0]              cur_cand, cur_code;
   logic [CNT_W-1:0]        cur_cnt, next_cnt;
   logic                    commit;

   function automatic logic [4:0] decode(input logic [6:0] p);
      case (p)
         7'b0000001: return {1'b1, 4'd0};
         7'b1001111: return {1'b1, 4'd1};
         7'b0010010: return {1'b1, 4'd2};
         7'b0000110: return {1'b1, 4'd3};
         7'b1001100: return {1'b1, 4'd4};
         7'b0100100: return {1'b1, 4'd5};
         7'b0100000: return {1'b1, 4'd6};
         7'b0001111: return {1'b1, 4'd7};
         7'b0000000: return {1'b1, 4'd8};
         7'b0000100: return {1'b1, 4'd9};
         7'b1111110: return {1'b1, 4'd10};
         7'b1111111: return {1'b1, 4'd15};
         default:    return {1'b0, 4'd0};
      endcase
   endfunction

   // two-flop synchronizers; idle bus level is all-high
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_s1 <= '1;
         seg_s2 <= '1;
         dig_s1 <= '1;
         dig_s2 <= '1;
      end else begin
         seg_s1 <= bus.seg_n;
         seg_s2 <= seg_s1;
         dig_s1 <= bus.dig_n;
         dig_s2 <= dig_s1;
      end
   end

   assign dig_low   = ~dig_s2;
   assign one_hot   = $onehot(dig_low);
   assign multi_low = !$onehot0(dig_low);
   assign {seg_ok, seg_code} = decode(seg_s2);

   // index of the strobe that is low (only used when exactly one is)
   always_comb begin
      hot_idx = '0;
      for (int i = 0; i < NUM_DIGITS; i++)
         if (dig_low[i]) hot_idx = IDX_W'(i);
   end

   // debounce outcome of the sample being taken for the latched digit
   always_comb begin
      cur_cand = cand[lat_idx];
      cur_cnt  = cnt[lat_idx];
      cur_code = digits[{lat_idx, 2'b00} +: 4];
      if (seg_code == cur_cand)
         next_cnt = (cur_cnt >= CNT_W'(STABLE_SCANS)) ? CNT_W'(STABLE_SCANS) : cur_cnt + 1'b1;
      else
         next_cnt = CNT_W'(1);
      commit = seg_ok && (next_cnt == CNT_W'(STABLE_SCANS)) &&
               (!valid[lat_idx] || (seg_code != cur_code));
   end

   // scan FSM with per-digit debounce and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         lat_vec     <= '1;
         lat_idx     <= '0;
         scnt        <= '0;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            cand[i] <= '0;
            cnt[i]  <= '0;
         end
         digits      <= {NUM_DIGITS{4'hF}};
         valid       <= '0;
         update      <= 1'b0;
         update_idx  <= '0;
         pattern_err <= 1'b0;
         scan_err    <= 1'b0;
      end else begin
         update      <= 1'b0;
         pattern_err <= 1'b0;
         scan_err    <= 1'b0;
         case (state)
            IDLE: begin
               if (one_hot) begin
                  lat_vec <= dig_s2;
                  lat_idx <= hot_idx;
                  scnt    <= '0;
                  state   <= SETTLE;
               end
            end
            SETTLE: begin
               if (dig_s2 != lat_vec) begin
                  state    <= IDLE;
                  scan_err <= multi_low;
               end else if (scnt == SET_W'(SETTLE_CYC - 1)) begin
                  state <= SAMPLE;
               end else begin
                  scnt <= scnt + 1'b1;
               end
            end
            SAMPLE: begin
               state <= HOLD;
               if (!seg_ok) begin
                  pattern_err  <= 1'b1;
                  cnt[lat_idx] <= '0;
               end else begin
                  cand[lat_idx] <= seg_code;
                  cnt[lat_idx]  <= next_cnt;
                  if (commit) begin
                     digits[{lat_idx, 2'b00} +: 4] <= seg_code;
                     valid[lat_idx] <= 1'b1;
                     update         <= 1'b1;
                     update_idx     <= lat_idx;
                  end
               end
            end
            HOLD: begin
               // all-high is a normal blanking gap, only multi-low is an error
               if (dig_s2 != lat_vec) begin
                  state    <= IDLE;
                  scan_err <= multi_low;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.digits_o      = digits;
   assign bus.valid_o       = valid;
   assign bus.update_o      = update;
   assign bus.update_idx_o  = update_idx;
   assign bus.pattern_err_o = pattern_err;
   assign bus.scan_err_o    = scan_err;
endmodule
